mem_port_arbiter: RTL and testbench

Shares one unified fixed-latency memory port between the pipeline's fetch stage (instruction read) and memory stage (data read/write). Runs a grant/issue/wait/respond FSM and returns data with a one-cycle valid pulse. Exports per-requester stall requests, which the top level ORs into the pipeline stall/bubble logic. Sits between the F/M stages and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 35 +++
 rtl/mem_port_arbiter_fetch_line_buf.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | mem_port_arbiter_pkg: shared FSM/owner encodings and defaults     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int unsigned c_DEF_ADDR_W     = 64;
  localparam int unsigned c_DEF_DATA_W     = 64;
  localparam int unsigned c_DEF_LINE_W     = 80;
  localparam int unsigned c_DEF_MEM_LAT    = 2;
  localparam int unsigned c_MIN_MEM_LAT    = 1;
  localparam int unsigned c_FETCH_LINE_LEN = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_M    = 2'd2
  } owner_e;

  function automatic bit mem_lat_ok(input int unsigned lat);
    return lat >= c_MIN_MEM_LAT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_fetch_line_buf.sv
// +------------------------------------------------------------------+
// | fetch_line_buf: one-entry last-fetched-line buffer, used only     |
// | when FETCH_LINE_BUF_EN is defined.  Revision: 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_line_buf
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = c_DEF_ADDR_W,
  parameter int unsigned LINE_W = c_DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [LINE_W-1:0] fill_line_i,
  input  logic              inv_i,
  input  logic [ADDR_W-1:0] inv_addr_i
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [ADDR_W-1:0] w_inv_off;

  // Unsigned offset test covers both ends of [addr, addr+9] in one compare.
  assign w_inv_off = inv_addr_i - addr_q;
  assign hit_o     = valid_q && (lookup_addr_i == addr_q);
  assign line_o    = line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
    end else if (inv_i && (w_inv_off < ADDR_W'(c_FETCH_LINE_LEN))) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr_i;
      line_q  <= fill_line_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +------------------------------------------------------------------+
// | mem_port_arbiter: fetch/data sharing of one fixed-latency memory  |
// | port. Optional line buffer: FETCH_LINE_BUF_EN. Revision: 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = c_DEF_ADDR_W,
  parameter int unsigned DATA_W  = c_DEF_DATA_W,
  parameter int unsigned LINE_W  = c_DEF_LINE_W,
  parameter int unsigned MEM_LAT = c_DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic [LINE_W-1:0] f_rdata_o,
  output logic              f_valid_o,
  output logic              f_err_o,
  output logic              f_stall_req_o,
  input  logic              m_req_i,
  input  logic              m_wr_i,
  input  logic [ADDR_W-1:0] m_addr_i,
  input  logic [DATA_W-1:0] m_wdata_i,
  output logic [DATA_W-1:0] m_rdata_o,
  output logic              m_valid_o,
  output logic              m_err_o,
  output logic              m_stall_req_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_err_i
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  generate
    if (!mem_lat_ok(MEM_LAT)) begin : g_lat_check
      $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end
  endgenerate

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;
  logic              err_q;

  logic              w_grant_m, w_grant_f, w_buf_hit, w_mem_active;
  logic [LINE_W-1:0] w_buf_line;

  // Data wins ties: it belongs to the older instruction.
  assign w_grant_m = (state_q == S_IDLE) && m_req_i;
  assign w_grant_f = (state_q == S_IDLE) && !m_req_i && f_req_i;

`ifdef FETCH_LINE_BUF_EN
  logic w_lookup_hit;
  fetch_line_buf #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_fetch_line_buf (
    .clk          (clk),
    .rst          (rst),
    .lookup_addr_i(f_addr_i),
    .hit_o        (w_lookup_hit),
    .line_o       (w_buf_line),
    .fill_i       ((state_q == S_WAIT) && (cnt_q == '0) && (owner_q == OWN_F) && !mem_err_i),
    .fill_addr_i  (addr_q),
    .fill_line_i  (mem_rdata_i),
    .inv_i        (w_grant_m && m_wr_i),
    .inv_addr_i   (m_addr_i)
  );
  assign w_buf_hit = w_grant_f && w_lookup_hit;
`else
  assign w_buf_hit  = 1'b0;
  assign w_buf_line = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_buf_hit) state_d = S_RESP;
               else if (w_grant_m || w_grant_f) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_grant_m) begin
            owner_q <= OWN_M;
            addr_q  <= m_addr_i;
            wr_q    <= m_wr_i;
            wdata_q <= m_wdata_i;
          end else if (w_grant_f) begin
            owner_q <= OWN_F;
            addr_q  <= f_addr_i;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            // Only matters on a buffer hit; a memory fetch overwrites it in WAIT.
            line_q  <= w_buf_line;
            err_q   <= 1'b0;
          end
        end
        S_ISSUE: cnt_q <= CNT_W'(MEM_LAT - 1);
        S_WAIT: begin
          if (cnt_q == '0) begin
            line_q <= mem_rdata_i;
            err_q  <= mem_err_i;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP:  owner_q <= OWN_NONE;
        default: owner_q <= OWN_NONE;
      endcase
    end
  end

  // A requester that dropped req before RESP gets no response.
  always_comb begin
    w_mem_active  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    mem_req_o     = (state_q == S_ISSUE);
    mem_wr_o      = w_mem_active && wr_q;
    mem_addr_o    = w_mem_active ? addr_q  : '0;
    mem_wdata_o   = w_mem_active ? wdata_q : '0;
    f_valid_o     = (state_q == S_RESP) && (owner_q == OWN_F) && f_req_i;
    m_valid_o     = (state_q == S_RESP) && (owner_q == OWN_M) && m_req_i;
    f_rdata_o     = f_valid_o ? line_q : '0;
    f_err_o       = f_valid_o && err_q;
    m_rdata_o     = (m_valid_o && !wr_q) ? line_q[DATA_W-1:0] : '0;
    m_err_o       = m_valid_o && err_q;
    f_stall_req_o = f_req_i && !f_valid_o;
    m_stall_req_o = m_req_i && !m_valid_o;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +------------------------------------------------------------------+
// | tb_mem_port_arbiter: scoreboard bench with a fixed-latency memory |
// | model. Revision: 1.0                                              |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int LINE_W  = 80;
  localparam int MEM_LAT = 2;

  logic              clk, rst;
  logic              f_req, f_valid_o, f_err_o, f_stall_req_o;
  logic [ADDR_W-1:0] f_addr;
  logic [LINE_W-1:0] f_rdata_o;
  logic              m_req, m_wr, m_valid_o, m_err_o, m_stall_req_o;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata_o;
  logic              mem_req_o, mem_wr_o, mem_err_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_rdata_o(f_rdata_o), .f_valid_o(f_valid_o),
    .f_err_o(f_err_o), .f_stall_req_o(f_stall_req_o),
    .m_req_i(m_req), .m_wr_i(m_wr), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_rdata_o(m_rdata_o), .m_valid_o(m_valid_o), .m_err_o(m_err_o), .m_stall_req_o(m_stall_req_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, n_memreq = 0;

  typedef struct { bit is_m; logic [79:0] data; logic err; int at; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [79:0] obs_data;
  logic        obs_err;

  function automatic logic [79:0] line_of(input logic [63:0] a);
    if (a == 64'h100) return 80'h30F2_0A00_0000_0000_0000;
    return {16'hC0DE, a ^ 64'h5555_0000_1234_0000};
  endfunction

  function automatic logic [79:0] low_of(input logic [63:0] a);
    logic [79:0] l;
    l = line_of(a);
    return {16'h0, l[63:0]};
  endfunction

  // Memory model: line valid only in the cycle MEM_LAT after mem_req; poisoned otherwise.
  logic [1:0]  rq_p = '0;
  logic [63:0] ad0 = '0, ad1 = '0;
  always @(posedge clk) begin
    rq_p <= {rq_p[0], mem_req_o};
    ad0  <= mem_addr_o;
    ad1  <= ad0;
  end
  assign mem_rdata_i = rq_p[1] ? line_of(ad1) : 80'hBAD0_BAD0_BAD0_BAD0_BAD0;
  assign mem_err_i   = rq_p[1] ? (ad1 == 64'h666) : 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_req_o === 1'b1) n_memreq++;
    if (f_valid_o === 1'b1 || m_valid_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: f_valid=%b m_valid=%b at cycle %0d, required no response",
                 f_valid_o, m_valid_o, cyc);
      end else begin
        mon_e    = sb.pop_front();
        obs_data = m_valid_o ? {16'h0, m_rdata_o} : f_rdata_o;
        obs_err  = m_valid_o ? m_err_o : f_err_o;
        if ((f_valid_o && m_valid_o) || (m_valid_o !== mon_e.is_m) || (obs_data !== mon_e.data) ||
            (obs_err !== mon_e.err) || (cyc !== mon_e.at)) begin
          errors++;
          $display("FAIL response: got m=%b data=%h err=%b cyc=%0d, required m=%b data=%h err=%b cyc=%0d",
                   m_valid_o, obs_data, obs_err, cyc, mon_e.is_m, mon_e.data, mon_e.err, mon_e.at);
        end
      end
    end
  end

  task automatic wait_drain;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; f_req = 0; f_addr = '0; m_req = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({f_rdata_o, f_valid_o, f_err_o, f_stall_req_o, m_rdata_o, m_valid_o, m_err_o, m_stall_req_o,
         mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: f_valid=%b m_valid=%b mem_req=%b mem_addr=%h, required all 0",
               f_valid_o, m_valid_o, mem_req_o, mem_addr_o);
    end
    checks++;
    if (dut.state_q !== S_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d, required IDLE", dut.state_q);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_fetch_read;
    int k, base;
    @(posedge clk); #1;
    f_req = 1; f_addr = 64'h100; k = cyc; base = n_memreq;
    sb.push_back('{1'b0, 80'h30F2_0A00_0000_0000_0000, 1'b0, k + 4});
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (f_stall_req_o !== 1'(i < 4)) begin
        errors++; $display("FAIL fetch_stall: offset %0d got %b, required %b", i, f_stall_req_o, i < 4);
      end
      if (i == 1) begin
        checks++;
        if ({mem_req_o, mem_wr_o, mem_addr_o} !== {1'b1, 1'b0, 64'h100}) begin
          errors++; $display("FAIL fetch_issue: req=%b wr=%b addr=%h, required 1 0 100", mem_req_o, mem_wr_o, mem_addr_o);
        end
      end
      if (i == 2) begin
        checks++;
        if (mem_req_o !== 1'b0) begin
          errors++; $display("FAIL fetch_req_pulse: mem_req=%b in WAIT, required 0", mem_req_o);
        end
      end
      @(posedge clk); #1;
      if (i == 4) f_req = 0;
    end
    wait_drain();
    checks++;
    if (n_memreq - base !== 1) begin
      errors++; $display("FAIL fetch_memreq_count: got %0d, required 1", n_memreq - base);
    end
  endtask

  task automatic test_simultaneous;
    int k, base;
    @(posedge clk); #1;
    f_req = 1; f_addr = 64'h180; m_req = 1; m_wr = 0; m_addr = 64'h200; k = cyc; base = n_memreq;
    sb.push_back('{1'b1, low_of(64'h200), 1'b0, k + 4});
    sb.push_back('{1'b0, line_of(64'h180), 1'b0, k + 9});
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i == 0 || i == 4) begin
        checks++;
        if ({f_stall_req_o, m_stall_req_o} !== {1'b1, 1'(i == 0)}) begin
          errors++; $display("FAIL simul_stall: offset %0d f=%b m=%b, required 1 %b", i, f_stall_req_o, m_stall_req_o, i == 0);
        end
      end
      if (i == 1 || i == 6) begin
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, (i == 1) ? 64'h200 : 64'h180}) begin
          errors++; $display("FAIL simul_issue: offset %0d req=%b addr=%h", i, mem_req_o, mem_addr_o);
        end
      end
      @(posedge clk); #1;
      if (i == 4) m_req = 0;
      if (i == 9) f_req = 0;
    end
    wait_drain();
    checks++;
    if (n_memreq - base !== 2) begin
      errors++; $display("FAIL simul_memreq_count: got %0d, required 2", n_memreq - base);
    end
  endtask

  task automatic test_write;
    @(posedge clk); #1;
    m_req = 1; m_wr = 1; m_addr = 64'h40; m_wdata = 64'hDEAD;
    sb.push_back('{1'b1, 80'h0, 1'b0, cyc + 4});
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1 || i == 2) begin
        checks++;
        if ({mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o} !== {1'(i == 1), 1'b1, 64'h40, 64'hDEAD}) begin
          errors++; $display("FAIL write_port: offset %0d req=%b wr=%b addr=%h wdata=%h, required %b 1 40 dead",
                             i, mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, i == 1);
        end
      end
      @(posedge clk); #1;
      if (i == 4) begin m_req = 0; m_wr = 0; end
    end
    wait_drain();
  endtask

  task automatic test_error;
    @(posedge clk); #1;
    m_req = 1; m_wr = 0; m_addr = 64'h666;
    sb.push_back('{1'b1, low_of(64'h666), 1'b1, cyc + 4});
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
      if (i == 4) m_req = 0;
    end
    wait_drain();
  endtask

  task automatic test_cancel;
    int base;
    @(posedge clk); #1;
    f_req = 1; f_addr = 64'h100; base = n_memreq;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (f_valid_o !== 1'b0) begin
          errors++; $display("FAIL cancel_valid: got %b, required 0", f_valid_o);
        end
      end
      if (i == 5) begin
        checks++;
        if (dut.state_q !== S_IDLE) begin
          errors++; $display("FAIL cancel_state: got %0d, required IDLE", dut.state_q);
        end
      end
      @(posedge clk); #1;
      if (i == 1) f_req = 0;
    end
    checks++;
    if (n_memreq - base !== 1) begin
      errors++; $display("FAIL cancel_memreq_count: got %0d, required 1", n_memreq - base);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    @(posedge clk); #1;
    f_req = 1; f_addr = 64'h100; base = n_memreq;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if ({f_rdata_o, f_valid_o, f_err_o, m_rdata_o, m_valid_o, m_err_o,
             mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o} !== '0 || dut.state_q !== S_IDLE) begin
          errors++; $display("FAIL reset_mid: state=%0d mem_addr=%h f_valid=%b, required IDLE/0/0",
                             dut.state_q, mem_addr_o, f_valid_o);
        end
      end
      @(posedge clk); #1;
      if (i == 1) rst = 1;
      if (i == 3) begin rst = 0; f_req = 0; end
    end
    checks++;
    if (n_memreq - base !== 1) begin
      errors++; $display("FAIL reset_mid_memreq_count: got %0d, required 1", n_memreq - base);
    end
  endtask

  task automatic test_back_to_back;
    int k, base;
    @(posedge clk); #1;
    m_req = 1; m_wr = 0; m_addr = 64'h10; k = cyc; base = n_memreq;
    sb.push_back('{1'b1, low_of(64'h10), 1'b0, k + 4});
    sb.push_back('{1'b1, low_of(64'h18), 1'b0, k + 9});
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
      if (i == 4) m_addr = 64'h18;
      if (i == 9) m_req = 0;
    end
    wait_drain();
    checks++;
    if (n_memreq - base !== 2) begin
      errors++; $display("FAIL b2b_memreq_count: got %0d, required 2", n_memreq - base);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_write();
    test_error();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
